// File: rtl/chebyshev_sign_extension.sv
// Re-widens narrowed Chebyshev words to WL bits, flags rail words,
// counts them, and buffers output through a 2-entry skid.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/ready  : producer handshake; in_ready is registered
//   in_data         : narrowed O_BITS two's-complement word
//   out_valid/ready : consumer handshake
//   out_data        : sign-extended WL-bit word
//   out_rail        : out_data came from a saturation-rail input
//   rail_count      : saturating count of accepted rail words
//   clear_count     : synchronous clear of rail_count
module chebyshev_sign_extension #(
  parameter  int WL                    = 16,
  parameter  int I_BITS                = 6,
  parameter  int BOUNDARY_BIT_POSITION = 3,
  parameter  int CNT_WIDTH             = 16,
  localparam int EXT    = I_BITS - BOUNDARY_BIT_POSITION,
  localparam int O_BITS = WL - EXT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [O_BITS-1:0]    in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WL-1:0]        out_data,
  output logic                 out_rail,
  output logic [CNT_WIDTH-1:0] rail_count,
  input  logic                 clear_count
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_TWO
  } state_t;

  localparam logic [O_BITS-1:0] POS_RAIL =
    {1'b0, {(O_BITS-1){1'b1}}};
  localparam logic [O_BITS-1:0] NEG_RAIL =
    {1'b1, {(O_BITS-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE =
    {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic                   in_ready_q, in_ready_d;
  logic [WL-1:0]          main_data_q, main_data_d;
  logic                   main_rail_q, main_rail_d;
  logic [WL-1:0]          skid_data_q, skid_data_d;
  logic                   skid_rail_q, skid_rail_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  logic                   in_xfer;
  logic                   out_xfer;
  logic [WL-1:0]          ext_word;
  logic                   in_rail;

  assign ext_word  = {{EXT{in_data[O_BITS-1]}}, in_data};
  assign in_rail   = (in_data == POS_RAIL) |
                     (in_data == NEG_RAIL);

  assign out_valid = (state_q != S_EMPTY);
  assign in_xfer   = in_valid & in_ready_q;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_rail_d = main_rail_q;
    skid_data_d = skid_data_q;
    skid_rail_d = skid_rail_q;
    unique case (state_q)
      S_EMPTY: begin
        if (in_xfer) begin
          main_data_d = ext_word;
          main_rail_d = in_rail;
          state_d     = S_ONE;
        end
      end
      S_ONE: begin
        if (in_xfer && out_xfer) begin
          main_data_d = ext_word;
          main_rail_d = in_rail;
        end else if (out_xfer) begin
          state_d     = S_EMPTY;
        end else if (in_xfer) begin
          // main is stalled; park the new word behind it
          skid_data_d = ext_word;
          skid_rail_d = in_rail;
          state_d     = S_TWO;
        end
      end
      S_TWO: begin
        if (out_xfer) begin
          main_data_d = skid_data_q;
          main_rail_d = skid_rail_q;
          state_d     = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    // registered ready: only a full skid blocks the producer
    in_ready_d = (state_d != S_TWO);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clear_count) begin
      cnt_d = (in_xfer && in_rail) ? CNT_ONE : '0;
    end else if (in_xfer && in_rail &&
                 (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      in_ready_q  <= 1'b0;
      main_data_q <= '0;
      main_rail_q <= 1'b0;
      skid_data_q <= '0;
      skid_rail_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_data_q <= main_data_d;
      main_rail_q <= main_rail_d;
      skid_data_q <= skid_data_d;
      skid_rail_q <= skid_rail_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_data   = main_data_q;
  assign out_rail   = main_rail_q;
  assign rail_count = cnt_q;

endmodule

// File: tb/tb_chebyshev_sign_extension.sv
// Scoreboard bench for chebyshev_sign_extension.
// Small counter width exercises rail_count saturation.
module tb_chebyshev_sign_extension;

  localparam int WL  = 16;
  localparam int OB  = 13;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [OB-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [WL-1:0] out_data;
  logic          out_rail;
  logic [CW-1:0] rail_count;
  logic          clear_count;

  int n_checks = 0;
  int n_errs   = 0;
  int n_pops   = 0;
  logic [WL:0] sb_q[$];
  logic [CW-1:0] cnt_m = '0;

  chebyshev_sign_extension #(
    .WL(16), .I_BITS(6),
    .BOUNDARY_BIT_POSITION(3),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rail(out_rail),
    .rail_count(rail_count),
    .clear_count(clear_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [WL:0] model(
    input logic [OB-1:0] d);
    logic [WL-1:0] e;
    logic r;
    e = d[OB-1] ? (16'hE000 | 16'(d)) : 16'(d);
    r = (d == 13'h0FFF) || (d == 13'h1000);
    return {r, e};
  endfunction

  // inputs are stable here; these are the next edge's transfers
  always @(negedge clk) begin
    logic [WL:0] e;
    chk("rail_count", 32'(rail_count), 32'(cnt_m));
    if (rst) begin
      sb_q.delete();
      cnt_m = '0;
    end else begin
      if (in_valid && in_ready)
        sb_q.push_back(model(in_data));
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'(1), 32'(0));
        end else begin
          e = sb_q.pop_front();
          n_pops++;
          chk("out_word", 32'({out_rail, out_data}),
              32'(e));
        end
      end
      if (clear_count)
        cnt_m = (in_valid && in_ready &&
                 model(in_data)[WL]) ? 4'd1 : 4'd0;
      else if (in_valid && in_ready &&
               model(in_data)[WL] && cnt_m != 4'hF)
        cnt_m = cnt_m + 4'd1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [OB-1:0] d);
    logic acc;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    do begin
      acc = in_ready;
      cyc();
      n++;
    end while (!acc && n < 50);
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", 32'(0), 32'(1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 50) begin
      cyc();
      n++;
    end
    chk("drain", 32'(sb_q.size()), 32'(0));
  endtask

  initial begin
    int p0;
    logic [OB-1:0] d;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    clear_count = 1'b0;

    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_ovalid", 32'(out_valid), 32'(0));
      chk("rst_iready", 32'(in_ready), 32'(0));
      chk("rst_odata", 32'(out_data), 32'(0));
      chk("rst_orail", 32'(out_rail), 32'(0));
      chk("rst_cnt", 32'(rail_count), 32'(0));
    end
    rst = 1'b0;
    chk("rel_iready0", 32'(in_ready), 32'(0));
    cyc();
    chk("rel_iready1", 32'(in_ready), 32'(1));
    cyc();
    chk("idle_ovalid", 32'(out_valid), 32'(0));

    send(13'h0123);
    chk("lat_valid", 32'(out_valid), 32'(1));
    chk("lat_data", 32'(out_data), 32'h0123);
    send(13'h1FFF);
    send(13'h0FFF);
    send(13'h1000);
    drain();
    chk("ext_cnt", 32'(rail_count), 32'(2));

    out_ready = 1'b0;
    send(13'h0001);
    send(13'h0002);
    chk("bp_iready", 32'(in_ready), 32'(0));
    chk("bp_hold", 32'(out_data), 32'h0001);
    in_valid = 1'b1;
    in_data  = 13'h0003;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_noacc", 32'(in_ready), 32'(0));
      chk("bp_stable", 32'(out_data), 32'h0001);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc();
    chk("bp_second", 32'(out_data), 32'h0002);
    chk("bp_iready1", 32'(in_ready), 32'(1));
    drain();

    p0 = n_pops;
    for (int i = 0; i < 100; i++) begin
      if (i % 10 == 3)      d = 13'h0FFF;
      else if (i % 10 == 7) d = 13'h1000;
      else                  d = 13'($urandom);
      in_valid = 1'b1;
      in_data  = d;
      chk("tp_iready", 32'(in_ready), 32'(1));
      cyc();
      chk("tp_ovalid", 32'(out_valid), 32'(1));
    end
    in_valid = 1'b0;
    drain();
    chk("tp_count", 32'(n_pops - p0), 32'(100));

    clear_count = 1'b1;
    cyc();
    clear_count = 1'b0;
    chk("clr0", 32'(rail_count), 32'(0));
    for (int i = 0; i < 20; i++)
      send((i % 2 == 0) ? 13'h0FFF : 13'h1000);
    drain();
    chk("cnt_sat", 32'(rail_count), 32'hF);
    clear_count = 1'b1;
    send(13'h1000);
    clear_count = 1'b0;
    chk("clr_rail", 32'(rail_count), 32'(1));
    clear_count = 1'b1;
    cyc();
    clear_count = 1'b0;
    chk("clr_alone", 32'(rail_count), 32'(0));
    drain();

    out_ready = 1'b0;
    send(13'h0FFF);
    send(13'h1000);
    chk("two_iready", 32'(in_ready), 32'(0));
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_ovalid", 32'(out_valid), 32'(0));
    chk("mid_cnt", 32'(rail_count), 32'(0));
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("no_stale", 32'(out_valid), 32'(0));
    end
    send(13'h0ABC);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/chebyshev_sign_extension.md
Name: chebyshev_sign_extension

Overview:
- Streaming re-widening stage, the inverse of the Chebyshev saturation/narrowing path.
- Accepts narrowed O_BITS words and sign-extends them back to the full WL datapath format, so later full-width accumulations can consume them.
- Flags words that sit exactly on a saturation rail, keeps a saturating count of them, and decouples producer from consumer with a 2-entry valid/ready skid buffer.

Parameters:
- WL, 16, full wordlength of the output word.
- I_BITS, 6, integer bits of the full-width format.
- BOUNDARY_BIT_POSITION, 3, saturation boundary used by the narrowing path.
- CNT_WIDTH, 16, width of the rail-hit counter.
- Derived localparam O_BITS = WL - (I_BITS - BOUNDARY_BIT_POSITION), 13 at defaults.
- Derived localparam EXT = I_BITS - BOUNDARY_BIT_POSITION, 3 at defaults.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  producer word valid.
- in_ready  output  1  stage can accept; registered.
- in_data  input  O_BITS  narrowed two's-complement word.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts.
- out_data  output  WL  sign-extended word.
- out_rail  output  1  out_data came from a saturation-rail input word.
- rail_count  output  CNT_WIDTH  number of accepted rail words, saturating.
- clear_count  input  1  synchronous clear of rail_count.

Behaviour:
- Reset (rst=1 at a clock edge): out_valid=0, in_ready=0, out_data=0, out_rail=0, rail_count=0, skid entry invalid. in_ready rises on the first edge with rst=0. No transfer is recognised while rst=1.
- Transfers:
  - Input transfer = in_valid & in_ready at the edge.
  - Output transfer = out_valid & out_ready at the edge.
- Extension: ext_word = {EXT copies of in_data[O_BITS-1], in_data}.
- Rail detect:
  - pos_rail: in_data == {1'b0, (O_BITS-1) ones}.
  - neg_rail: in_data == {1'b1, (O_BITS-1) zeros}.
  - rail = pos_rail | neg_rail, computed on input and stored alongside the data.
- Latency: 1 cycle. A word accepted at edge N appears on out_data/out_rail after edge N when the stage was empty.
- Skid FSM:
  - EMPTY: out_valid=0, in_ready=1. Input transfer -> load main register -> ONE.
  - ONE: out_valid=1, in_ready=1.
    - Input and output transfer together: main reloads -> stay ONE.
    - Output only -> EMPTY.
    - Input only (out_ready=0): word goes to skid -> TWO, in_ready becomes 0 next cycle.
  - TWO: out_valid=1, in_ready=0. Output transfer: skid moves to main -> ONE. Otherwise hold.
- Sustained throughput: 1 word/cycle with out_ready held high.
- Order is preserved and no word is dropped or duplicated.
- Output stability: out_data/out_rail stay stable while out_valid=1 and out_ready=0.
- rail_count:
  - Increments by 1 on each input transfer with rail=1.
  - Holds at all-ones with no wrap-around.
  - clear_count=1 forces 0, unless the same edge has a rail input transfer, in which case it forces 1.
  - rst overrides clear_count.
- Reset mid-operation: rst discards the buffered words (main and skid), and the state returns to EMPTY on that edge.

Test Plan (defaults WL=16, I_BITS=6, BOUNDARY_BIT_POSITION=3):
- Reset and release:
  - Stimulus: rst=1 for 3 cycles, then rst=0.
  - Response: all outputs 0 during reset; in_ready=1 one edge after release; out_valid stays 0 with in_valid=0.
- Extension values, out_ready=1:
  - Stimulus: send 13'h0123, 13'h1FFF, 13'h0FFF, 13'h1000.
  - Response: out_data 16'h0123/rail 0, 16'hFFFF/0, 16'h0FFF/1, 16'hF000/1, each one cycle after acceptance; rail_count=2.
- Backpressure:
  - Stimulus: out_ready=0, send A=13'h0001 then B=13'h0002.
  - Response: in_ready=0 after B; out_data holds 16'h0001; C is not accepted.
  - Stimulus continued: out_ready=1.
  - Response: 16'h0001 then 16'h0002 emitted; in_ready returns to 1.
- Full throughput:
  - Stimulus: 100 consecutive words with in_valid=1 and out_ready=1.
  - Response: 100 outputs on consecutive cycles, in order, with in_ready constantly 1.
- Counter edges:
  - Stimulus: CNT_WIDTH=4, push 20 rail words.
  - Response: rail_count sticks at 4'hF.
  - Stimulus: clear_count coinciding with a rail word.
  - Response: rail_count=1.
  - Stimulus: clear_count alone.
  - Response: rail_count=0.
- Reset mid-flight:
  - Stimulus: reach TWO, then pulse rst=1 for 1 cycle.
  - Response: out_valid=0 and rail_count=0 after the edge; no stale word ever appears afterwards.
